// File: rtl/enigma_sequencer.sv
// Purpose : sequences one shared rotor/reflector substitution stage to encipher a character
//           (odometer step with double-step, then seven stage passes r1f r2f r3f refl r3b r2b r1b).
// Latency : accept at edge T -> out_valid sampled at T+2+7(L+1) for stage latency L; pass-through symbols at T+1.
// Backpr. : one character in flight; in_ready low outside IDLE; OUT holds dout/out_valid until out_ready.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_set, i_off1..3          load rotor positions (mod ALPHA), abort transaction, clear err
//   i_en                      allows acceptance of new characters
//   i_in_valid/o_in_ready     input character handshake, i_din symbol index
//   o_stg_valid/sel/dir/din   one-cycle request to the shared stage
//   i_stg_done/i_stg_dout     stage result
//   o_pos1..3                 current rotor positions
//   o_out_valid/i_out_ready   output handshake, o_dout enciphered symbol
//   o_err                     sticky stage-timeout flag
module enigma_sequencer #(
   parameter int ALPHA   = 26,
   parameter int NOTCH1  = 16,
   parameter int NOTCH2  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_set,
   input  logic       i_en,
   input  logic [4:0] i_off1,
   input  logic [4:0] i_off2,
   input  logic [4:0] i_off3,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   input  logic [7:0] i_din,
   output logic       o_stg_valid,
   output logic [1:0] o_stg_sel,
   output logic       o_stg_dir,
   output logic [7:0] o_stg_din,
   input  logic       i_stg_done,
   input  logic [7:0] i_stg_dout,
   output logic [4:0] o_pos1,
   output logic [4:0] o_pos2,
   output logic [4:0] o_pos3,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic [7:0] o_dout,
   output logic       o_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_STEP  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [7:0] ALPHA8   = 8'(ALPHA);
   localparam logic [4:0] ALPHA5   = 5'(ALPHA);
   localparam logic [4:0] LAST5    = 5'(ALPHA - 1);
   localparam logic [4:0] NOTCH1_5 = 5'(NOTCH1);
   localparam logic [4:0] NOTCH2_5 = 5'(NOTCH2);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [2:0] PASS_LAST = 3'd6;

   logic [2:0] r_state;
   logic [4:0] r_pos1, r_pos2, r_pos3;
   logic [2:0] r_pass;
   logic [7:0] r_data;
   logic [7:0] r_tmo;
   logic       r_err;

   logic       w_accept;
   logic       w_step2;
   logic       w_step3;
   logic [2:0] w_back_idx;

   // Offsets are 5 bits wide, so a single conditional subtract reduces them mod ALPHA.
   function automatic logic [4:0] f_mod(input logic [4:0] v);
      return (v >= ALPHA5) ? (v - ALPHA5) : v;
   endfunction

   function automatic logic [4:0] f_inc(input logic [4:0] v);
      return (v == LAST5) ? 5'd0 : (v + 5'd1);
   endfunction

   assign o_in_ready = (r_state == S_IDLE) & i_en & ~i_set;
   assign w_accept   = i_in_valid & o_in_ready;

   // Odometer carries evaluated on pre-step positions; pos2 == NOTCH2 is the double-step.
   assign w_step2 = (r_pos1 == NOTCH1_5) | (r_pos2 == NOTCH2_5);
   assign w_step3 = (r_pos2 == NOTCH2_5);

   // Passes 4..6 walk the rotors back down: 6-pass gives rotor 2,1,0.
   assign w_back_idx = PASS_LAST - r_pass;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_pos1  <= 5'd0;
         r_pos2  <= 5'd0;
         r_pos3  <= 5'd0;
         r_pass  <= 3'd0;
         r_data  <= 8'd0;
         r_tmo   <= 8'd0;
         r_err   <= 1'b0;
      end else if (i_set) begin
         r_state <= S_IDLE;
         r_pos1  <= f_mod(i_off1);
         r_pos2  <= f_mod(i_off2);
         r_pos3  <= f_mod(i_off3);
         r_pass  <= 3'd0;
         r_tmo   <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_data  <= i_din;
                  r_state <= (i_din < ALPHA8) ? S_STEP : S_OUT;
               end
            end
            S_STEP: begin
               r_pos1 <= f_inc(r_pos1);
               if (w_step2) r_pos2 <= f_inc(r_pos2);
               if (w_step3) r_pos3 <= f_inc(r_pos3);
               r_pass  <= 3'd0;
               r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               r_tmo   <= 8'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_stg_done) begin
                  r_data <= i_stg_dout;
                  if (r_pass == PASS_LAST) begin
                     r_state <= S_OUT;
                  end else begin
                     r_pass  <= r_pass + 3'd1;
                     r_state <= S_ISSUE;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  // Stage is unresponsive: drop the character, flag it.
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end
            S_OUT: begin
               if (i_out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Stage select/direction are decoded from the pass counter, so they hold
   // naturally through WAIT (the counter only moves on the WAIT->ISSUE edge).
   assign o_stg_valid = (r_state == S_ISSUE);
   assign o_stg_sel   = (r_pass <= 3'd3) ? r_pass[1:0] : w_back_idx[1:0];
   assign o_stg_dir   = (r_pass >= 3'd4);
   assign o_stg_din   = r_data;

   assign o_pos1      = r_pos1;
   assign o_pos2      = r_pos2;
   assign o_pos3      = r_pos3;
   assign o_out_valid = (r_state == S_OUT);
   assign o_dout      = r_data;
   assign o_err       = r_err;

endmodule

// File: tb/tb_enigma_sequencer.sv
// Purpose : randomized + directed scoreboard bench for enigma_sequencer with a behavioural stage model.
// Latency : expected results queued at acceptance, popped by the monitor on each output handshake.
// Backpr. : exercises out_ready stalls, en gating, set/timeout/reset aborts.
module tb_enigma_sequencer;

   logic       clk = 1'b0;
   logic       reset, set, en;
   logic [4:0] off1, off2, off3;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din;
   logic       stg_valid;
   logic [1:0] stg_sel;
   logic       stg_dir;
   logic [7:0] stg_din;
   logic       stg_done;
   logic [7:0] stg_dout;
   logic [4:0] pos1, pos2, pos3;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic       err;

   always #5 clk = ~clk;

   enigma_sequencer dut (
      .i_clk(clk), .i_reset(reset), .i_set(set), .i_en(en),
      .i_off1(off1), .i_off2(off2), .i_off3(off3),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_din(din),
      .o_stg_valid(stg_valid), .o_stg_sel(stg_sel), .o_stg_dir(stg_dir), .o_stg_din(stg_din),
      .i_stg_done(stg_done), .i_stg_dout(stg_dout),
      .o_pos1(pos1), .o_pos2(pos2), .o_pos3(pos3),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_dout(dout), .o_err(err)
   );

   typedef struct {
      logic [7:0] d;
      int         p1, p2, p3;
   } exp_t;

   exp_t sb[$];
   int   seq_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   rise_cyc = 0;
   int   n_issue = 0;
   int   stage_mode = 0;   // 0: +1 mod 26, 1: position dependent, 2: never answers
   int   lat = 1;
   int   m1 = 0, m2 = 0, m3 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Behaviour of the external substitution stage (the datapath this block drives).
   function automatic int stage_f(input int mode, input int sel, input int dir, input int x,
                                  input int p1, input int p2, input int p3);
      int p;
      if (mode == 0) return (x + 1) % 26;
      if (sel == 3) return x ^ 1;
      p = (sel == 0) ? p1 : (sel == 1) ? p2 : p3;
      if (dir == 0) return (x + p + 3 * (sel + 1)) % 26;
      return (x + 2 * p + sel + 1) % 26;
   endfunction

   // Reference: odometer step on plain integers, then the fixed seven-pass route.
   task automatic model_step();
      bit c2, c3;
      c2 = (m1 == 16) || (m2 == 4);
      c3 = (m2 == 4);
      m1 = (m1 + 1) % 26;
      if (c2) m2 = (m2 + 1) % 26;
      if (c3) m3 = (m3 + 1) % 26;
   endtask

   function automatic int ref_cipher(input int x);
      int route[7];
      int v;
      route = '{0, 1, 2, 3, 2, 1, 0};
      v = x;
      for (int i = 0; i < 7; i++)
         v = stage_f(stage_mode, route[i], (i >= 4) ? 1 : 0, v, m1, m2, m3);
      return v;
   endfunction

   // Stage model: answers L cycles after sampling stg_valid, using the DUT-supplied positions.
   initial begin : stage_proc
      int s, d, x, r;
      stg_done = 1'b0;
      stg_dout = 8'd0;
      forever begin
         @(negedge clk);
         if (stg_valid === 1'b1) begin
            s = int'(stg_sel);
            d = int'(stg_dir);
            x = int'(stg_din);
            n_issue++;
            seq_q.push_back(d * 4 + s);
            r = stage_f(stage_mode, s, d, x, int'(pos1), int'(pos2), int'(pos3));
            if (stage_mode != 2) begin
               repeat (lat) @(posedge clk);
               #1;
               stg_done = 1'b1;
               stg_dout = r[7:0];
               @(posedge clk);
               #1;
               stg_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops and compares on every output handshake.
   initial begin : monitor_proc
      exp_t e;
      logic prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && prev_ov !== 1'b1) rise_cyc = cyc;
         prev_ov = out_valid;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=dout %0d required=no output", dout);
            end else begin
               e = sb.pop_front();
               chk("dout", dout, e.d);
               chk("pos1", pos1, e.p1);
               chk("pos2", pos2, e.p2);
               chk("pos3", pos3, e.p3);
            end
         end
      end
   end

   task automatic do_set(input int a, input int b, input int c);
      off1 = a[4:0];
      off2 = b[4:0];
      off3 = c[4:0];
      set  = 1'b1;
      @(posedge clk);
      #1;
      set = 1'b0;
      m1 = a % 26;
      m2 = b % 26;
      m3 = c % 26;
   endtask

   task automatic send(input int d);
      exp_t e;
      int   t;
      in_valid = 1'b1;
      din      = d[7:0];
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         t++;
         if (t > 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready low required=accept within 100 cycles");
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc = cyc;
      if (d < 26) begin
         model_step();
         e.d = 8'(ref_cipher(d));
      end else begin
         e.d = d[7:0];
      end
      e.p1 = m1;
      e.p2 = m2;
      e.p3 = m3;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL output_timeout actual=%0d pending required=0 pending", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : main
      int   base, t, h, d;
      exp_t junk;
      reset = 1'b1; set = 1'b0; en = 1'b1;
      off1 = 5'd0; off2 = 5'd0; off3 = 5'd0;
      in_valid = 1'b0; din = 8'd0; out_ready = 1'b1;

      #1;
      chk("rst_stg_valid", stg_valid, 0);
      chk("rst_stg_sel", stg_sel, 0);
      chk("rst_stg_dir", stg_dir, 0);
      chk("rst_stg_din", stg_din, 0);
      chk("rst_pos", {pos1, pos2, pos3}, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_err", err, 0);
      #20;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed: +1 stage, L=1, din=5 -> 12, route order, latency 16.
      stage_mode = 0; lat = 1;
      do_set(0, 0, 0);
      seq_q.delete();
      send(5);
      wait_idle();
      chk("lat_full", rise_cyc + 1 - acc_cyc, 16);
      chk("route_len", seq_q.size(), 7);
      begin
         int exp_route[7];
         exp_route = '{0, 1, 2, 3, 6, 5, 4};
         for (int i = 0; i < 7; i++)
            if (i < seq_q.size()) chk($sformatf("route_%0d", i), seq_q[i], exp_route[i]);
      end
      chk("first_pos1", pos1, 1);
      chk("first_pos23", {pos2, pos3}, 0);

      // Double-step from (16,4,7), then an ordinary step.
      stage_mode = 1;
      do_set(16, 4, 7);
      send(10);
      wait_idle();
      chk("dstep_pos", {pos1, pos2, pos3}, {5'd17, 5'd5, 5'd8});
      send(20);
      wait_idle();
      chk("after_dstep_pos", {pos1, pos2, pos3}, {5'd18, 5'd5, 5'd8});

      // Wrap of pos1 at 25.
      do_set(25, 25, 25);
      send(0);
      wait_idle();
      chk("wrap_pos", {pos1, pos2, pos3}, {5'd0, 5'd25, 5'd25});

      // Pass-through symbol.
      base = n_issue;
      send(8'h41);
      wait_idle();
      chk("pt_latency", rise_cyc + 1 - acc_cyc, 1);
      chk("pt_no_issue", n_issue - base, 0);

      // Output backpressure hold.
      out_ready = 1'b0;
      send(11);
      t = 0;
      while (out_valid !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("hold_reach", out_valid, 1);
      h = int'(dout);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_dout", dout, h);
         chk("hold_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
      wait_idle();

      // en low blocks acceptance.
      en = 1'b0;
      in_valid = 1'b1;
      din = 8'd4;
      repeat (3) begin
         @(negedge clk);
         chk("en_low_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      en = 1'b1;

      // Stage timeout.
      stage_mode = 2;
      do_set(3, 9, 11);
      send(7);
      junk = sb.pop_back();
      t = 0;
      while (err !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("tmo_err", err, 1);
      chk("tmo_cycles", cyc - acc_cyc, 257);
      chk("tmo_idle", in_ready, 1);
      idle_cycles(5);
      do_set(3, 9, 11);
      chk("set_clears_err", err, 0);

      // set during pass 3.
      stage_mode = 0; lat = 2;
      base = n_issue;
      send(3);
      junk = sb.pop_back();
      t = 0;
      while (n_issue - base < 4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("reach_pass3", n_issue - base, 4);
      @(posedge clk);
      #1;
      do_set(30, 2, 9);
      idle_cycles(40);
      chk("abort_pos", {pos1, pos2, pos3}, {5'd4, 5'd2, 5'd9});
      chk("abort_out_valid", out_valid, 0);

      // Async reset during WAIT.
      stage_mode = 2; lat = 1;
      do_set(5, 6, 7);
      send(9);
      junk = sb.pop_back();
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_pos", {pos1, pos2, pos3}, 0);
      chk("arst_stg", {stg_valid, stg_sel, stg_dir, stg_din}, 0);
      chk("arst_out", {out_valid, dout, err}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m1 = 0; m2 = 0; m3 = 0;

      // Randomized traffic.
      stage_mode = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0)
            do_set(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         lat = int'($urandom_range(1, 3));
         d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(26, 255)) : int'($urandom_range(0, 25));
         en = 1'b1;
         send(d);
         en = 1'($urandom_range(0, 1));
         wait_idle();
         en = 1'b1;
      end

      idle_cycles(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
